// File: rtl/vec_chunk_fifo_if.sv
// vec_chunk_fifo_if: chunk write/read bus for vec_chunk_fifo; err_out exists only with VEC_CHUNK_FIFO_ERR_EN.
interface vec_chunk_fifo_if #(
    parameter int InVecLength = 8,
    parameter int WorkingRegs = 2,
    parameter int NBits = 8,
    parameter int DepthVecs = 2
);
    localparam int Depth = DepthVecs * InVecLength / WorkingRegs;
    localparam int OccW = $clog2(Depth) + 1;
    logic wr_en;
    logic [WorkingRegs-1:0][NBits-1:0] wr_data;
    logic wr_full;
    logic req_chunk;
    logic [WorkingRegs-1:0][NBits-1:0] rd_data;
    logic rd_last;
    logic vec_ready;
    logic [OccW-1:0] occupancy;
`ifdef VEC_CHUNK_FIFO_ERR_EN
    logic [1:0] err_out;
`endif
    modport master (
`ifdef VEC_CHUNK_FIFO_ERR_EN
        input err_out,
`endif
        output wr_en, wr_data, req_chunk,
        input wr_full, rd_data, rd_last, vec_ready, occupancy
    );
    modport slave (
`ifdef VEC_CHUNK_FIFO_ERR_EN
        output err_out,
`endif
        input wr_en, wr_data, req_chunk,
        output wr_full, rd_data, rd_last, vec_ready, occupancy
    );
endinterface

// File: rtl/vec_chunk_fifo.sv
// vec_chunk_fifo: FWFT chunk FIFO with whole-vector-ready flag for mlops stages.
// VEC_CHUNK_FIFO_ERR_EN adds sticky overflow/underflow flags on err_out.
module vec_chunk_fifo #(
    parameter int InVecLength = 8,
    parameter int WorkingRegs = 2,
    parameter int NBits = 8,
    parameter int DepthVecs = 2
) (
    input logic clk_in,
    input logic rst_in,
    vec_chunk_fifo_if.slave fifo
);
    localparam int ChunksPerVec = InVecLength / WorkingRegs;
    localparam int Depth = DepthVecs * ChunksPerVec;
    localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int OccW = $clog2(Depth) + 1;
    localparam int IdxW = ChunksPerVec > 1 ? $clog2(ChunksPerVec) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    logic [WorkingRegs-1:0][NBits-1:0] mem [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [OccW-1:0] occ, occ_nxt;
    logic [IdxW-1:0] rd_idx, idx_nxt;
    state_t state, state_nxt;
    logic push, pop, vec_ready_q;

    assign pop = fifo.req_chunk && occ != '0;
    assign push = fifo.wr_en && (!fifo.wr_full || pop);
    assign occ_nxt = occ + OccW'(push) - OccW'(pop);
    assign fifo.wr_full = occ == OccW'(Depth);
    assign fifo.occupancy = occ;
    assign fifo.rd_data = occ != '0 ? mem[rd_ptr] : '0;
    assign fifo.rd_last = rd_idx == IdxW'(ChunksPerVec - 1) && occ != '0;
    assign fifo.vec_ready = vec_ready_q;

    // Single-chunk vectors never leave IDLE; otherwise the first pop starts a vector
    always_comb begin
        state_nxt = state;
        idx_nxt = rd_idx;
        if (pop && state == IDLE) begin
            state_nxt = ChunksPerVec > 1 ? STREAM : IDLE;
            idx_nxt = ChunksPerVec > 1 ? IdxW'(1) : '0;
        end else if (pop) begin
            state_nxt = fifo.rd_last ? IDLE : STREAM;
            idx_nxt = fifo.rd_last ? '0 : rd_idx + IdxW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
            rd_idx <= '0;
            state <= IDLE;
            vec_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PtrW'(Depth - 1) ? '0 : wr_ptr + PtrW'(1);
            if (pop) rd_ptr <= rd_ptr == PtrW'(Depth - 1) ? '0 : rd_ptr + PtrW'(1);
            occ <= occ_nxt;
            rd_idx <= idx_nxt;
            state <= state_nxt;
            vec_ready_q <= occ_nxt >= OccW'(ChunksPerVec) - OccW'(idx_nxt);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= fifo.wr_data;
    end

`ifdef VEC_CHUNK_FIFO_ERR_EN
    logic [1:0] err_q;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) err_q <= '0;
        else err_q <= err_q | {fifo.req_chunk && occ == '0, fifo.wr_en && !push};
    end
    assign fifo.err_out = err_q;
`endif
endmodule

// File: tb/tb_vec_chunk_fifo.sv
// tb_vec_chunk_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_vec_chunk_fifo;
    localparam int IVL = 8, WR = 2, NB = 8, DV = 2;
    localparam int CPV = IVL / WR, DEPTH = DV * CPV;

    logic clk_in = 0;
    logic rst_in = 0;
    vec_chunk_fifo_if #(.InVecLength(IVL), .WorkingRegs(WR), .NBits(NB), .DepthVecs(DV)) bus ();
    vec_chunk_fifo #(.InVecLength(IVL), .WorkingRegs(WR), .NBits(NB), .DepthVecs(DV)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .fifo(bus)
    );

    always #5 clk_in = ~clk_in;

    logic [WR*NB-1:0] q[$];
    int rd_cnt;
    logic [1:0] err_m;
    int errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WR*NB-1:0] mk(input int a, input int b);
        return {8'(b), 8'(a)};
    endfunction

    task automatic check_all(input string t);
        int n = q.size();
        check({t, ":occ"}, 64'(bus.occupancy), 64'(n));
        check({t, ":full"}, 64'(bus.wr_full), 64'(n == DEPTH));
        check({t, ":rd_data"}, 64'(bus.rd_data), n != 0 ? 64'(q[0]) : 64'd0);
        check({t, ":rd_last"}, 64'(bus.rd_last), 64'(n != 0 && rd_cnt == CPV - 1));
        check({t, ":vec_ready"}, 64'(bus.vec_ready), 64'(n >= CPV - rd_cnt));
`ifdef VEC_CHUNK_FIFO_ERR_EN
        check({t, ":err"}, 64'(bus.err_out), 64'(err_m));
`endif
    endtask

    task automatic step(input string t, input logic we, input logic [WR*NB-1:0] d, input logic req);
        bit do_pop, do_push;
        bus.wr_en = we;
        bus.wr_data = d;
        bus.req_chunk = req;
        @(posedge clk_in);
        do_pop = req && q.size() != 0;
        do_push = we && (q.size() < DEPTH || do_pop);
        err_m = err_m | {req && q.size() == 0, we && !do_push};
        if (do_pop) begin
            void'(q.pop_front());
            rd_cnt = (rd_cnt + 1) % CPV;
        end
        if (do_push) q.push_back(d);
        @(negedge clk_in);
        bus.wr_en = 0;
        bus.req_chunk = 0;
        check_all(t);
    endtask

    task automatic do_reset(input string t);
        @(negedge clk_in);
        rst_in = 0;
        q.delete();
        rd_cnt = 0;
        err_m = 0;
        #1 check_all(t);
        @(negedge clk_in);
        rst_in = 1;
    endtask

    initial begin
        bus.wr_en = 0;
        bus.req_chunk = 0;
        bus.wr_data = '0;
        rd_cnt = 0;
        err_m = 0;
        do_reset("reset");
        // 1: partial vector then completing chunk
        step("t1", 1, mk(1, 2), 0);
        step("t1", 1, mk(3, 4), 0);
        step("t1", 1, mk(5, 6), 0);
        check("t1_rd", 64'(bus.rd_data), 64'h0201);
        check("t1_vr0", 64'(bus.vec_ready), 64'd0);
        step("t1", 1, mk(7, 8), 0);
        check("t1_vr1", 64'(bus.vec_ready), 64'd1);
        // 2: drain the vector
        for (int i = 0; i < 4; i++) step("t2", 0, '0, 1);
        check("t2_empty", 64'(bus.rd_data), 64'd0);
        // 3: fill, overflow, push+pop while full
        do_reset("t3_rst");
        for (int i = 0; i < DEPTH; i++) step("t3", 1, mk(16 + i, 32 + i), 0);
        check("t3_full", 64'(bus.wr_full), 64'd1);
        step("t3_ovf", 1, mk(99, 99), 0);
        check("t3_occ", 64'(bus.occupancy), 64'd8);
        step("t3_pp", 1, mk(77, 78), 1);
        for (int i = 0; i < DEPTH; i++) step("t3_drain", 0, '0, 1);
        // 4: push+pop on empty
        do_reset("t4_rst");
        step("t4", 1, mk(9, 10), 1);
        check("t4_occ", 64'(bus.occupancy), 64'd1);
        // 5: reset mid-vector
        do_reset("t5_rst");
        for (int i = 0; i < 4; i++) step("t5", 1, mk(i, i + 1), 0);
        step("t5", 0, '0, 1);
        step("t5", 0, '0, 1);
        do_reset("t5_mid");
        for (int i = 0; i < 4; i++) step("t5_refill", 1, mk(40 + i, 50 + i), 0);
        check("t5_vr", 64'(bus.vec_ready), 64'd1);
        // 6: pointer wrap
        do_reset("t6_rst");
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++) step("t6_push", 1, mk(v * 16 + i, 100 + v), 0);
            for (int i = 0; i < 4; i++) step("t6_pop", 0, '0, 1);
        end
        // random traffic
        do_reset("rnd_rst");
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("rnd_mid_rst");
            step("rnd", $urandom_range(0, 99) < 55, WR*NB'($urandom), $urandom_range(0, 99) < 50);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
